// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared systolic-array column constants and result vector type
package sa_pkg;

  localparam int SA_NUM_PE    = 4;
  localparam int SA_RES_W     = 32;
  localparam int SA_DRAIN_LAT = 4;
  localparam int SA_VEC_DEPTH = 2;

  typedef logic [SA_NUM_PE*SA_RES_W-1:0] sa_res_vec_t;

endpackage

// File: rtl/sa_vec_fifo.sv
// rtl/sa_vec_fifo.sv - synchronous FIFO of captured result vectors
// Exposes the head and the entry behind it so the drain can chain vectors without a bubble.
module sa_vec_fifo
  import sa_pkg::*;
#(
  parameter int W     = $bits(sa_res_vec_t),
  parameter int DEPTH = SA_VEC_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head,
  output logic [W-1:0]             next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign next    = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sa_col_drain.sv
// rtl/sa_col_drain.sv - captures a column's PE results after the fire latency and streams them out
// One word per beat, word 0 first; a vector is popped when its last word is accepted.
module sa_col_drain
  import sa_pkg::*;
#(
  parameter int NUM_PE    = SA_NUM_PE,
  parameter int RES_W     = SA_RES_W,
  parameter int DRAIN_LAT = SA_DRAIN_LAT,
  parameter int VEC_DEPTH = SA_VEC_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fire_in,
  input  logic [NUM_PE*RES_W-1:0]    result_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RES_W-1:0]           out_data,
  output logic [$clog2(NUM_PE)-1:0]  out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic                       overflow
);

  localparam int IDX_W = $clog2(NUM_PE);
  localparam int CNT_W = $clog2(VEC_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

  logic [DRAIN_LAT-1:0]      delay_line;
  logic                      strobe;
  logic [NUM_PE*RES_W-1:0]   head_vec;
  logic [NUM_PE*RES_W-1:0]   next_vec;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic                      accept;
  logic                      pop;
  logic [IDX_W-1:0]          idx_nxt;

  assign strobe  = delay_line[DRAIN_LAT-1];
  assign accept  = out_valid & out_ready;
  assign pop     = accept & out_last;
  assign idx_nxt = out_idx + IDX_W'(1);
  assign busy    = (|delay_line) | (fifo_count != '0) | out_valid;

  sa_vec_fifo #(
    .W     (NUM_PE*RES_W),
    .DEPTH (VEC_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (strobe),
    .push_data (result_in),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head_vec),
    .next      (next_vec)
  );

  // One bit per fire in flight; each pulse surfaces at the MSB exactly DRAIN_LAT cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_line <= '0;
    end else begin
      delay_line <= (delay_line << 1) | DRAIN_LAT'(fire_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (strobe && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      if (!out_last) begin
        out_idx  <= idx_nxt;
        out_data <= head_vec[int'(idx_nxt)*RES_W +: RES_W];
        out_last <= (idx_nxt == LAST_IDX);
      end else if (fifo_count > CNT_W'(1)) begin
        // Another vector already queued behind the head: chain straight into its word 0.
        out_idx  <= '0;
        out_data <= next_vec[RES_W-1:0];
        out_last <= (NUM_PE == 1);
      end else begin
        out_valid <= 1'b0;
        out_idx   <= '0;
        out_last  <= 1'b0;
      end
    end else if (!out_valid && !fifo_empty) begin
      out_valid <= 1'b1;
      out_idx   <= '0;
      out_data  <= head_vec[RES_W-1:0];
      out_last  <= (NUM_PE == 1);
    end
  end

endmodule

// File: tb/tb_sa_col_drain.sv
// tb/tb_sa_col_drain.sv - scoreboard bench for sa_col_drain
module tb_sa_col_drain;
  import sa_pkg::*;

  localparam int NP    = SA_NUM_PE;
  localparam int RW    = SA_RES_W;
  localparam int DL    = SA_DRAIN_LAT;
  localparam int DEPTH = SA_VEC_DEPTH;
  localparam int IW    = $clog2(NP);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fire_in = 1'b0;
  logic              out_ready = 1'b0;
  logic [NP*RW-1:0]  result_in = '0;
  logic              out_valid;
  logic [RW-1:0]     out_data;
  logic [IW-1:0]     out_idx;
  logic              out_last;
  logic              busy;
  logic              overflow;

  sa_col_drain dut (
    .clk       (clk),
    .rst       (rst),
    .fire_in   (fire_in),
    .result_in (result_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t sb[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    words_seen = 0;
  int    accepted = 0;
  int    drops = 0;
  bit    rand_res = 1'b0;

  // Reference model: vector occupancy, presented word and fire history by cycle number.
  int    cyc = 0;
  int    occ = 0;
  int    m_word = 0;
  bit    m_valid = 1'b0;
  bit    fire_hist[int];

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fire_in = 1'b0;
    out_ready = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_valid(string name, int max);
    int i = 0;
    while (!out_valid && i < max) begin
      step(1);
      i++;
    end
    chk(name, 64'(out_valid), 64'(1));
  endtask

  task automatic drain(string name);
    int i = 0;
    fire_in = 1'b0;
    out_ready = 1'b1;
    while ((busy || sb.size() != 0) && i < 300) begin
      step(1);
      i++;
    end
    chk(name, 64'(busy), 64'(0));
    chk(name, 64'(sb.size()), 64'(0));
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_res) begin
      for (int k = 0; k < NP; k++) result_in[k*RW +: RW] = $urandom;
    end
  end

  initial forever begin
    bit hs, fin;
    int prev, remain;
    @(posedge clk or posedge rst);
    if (rst) begin
      occ = 0; m_valid = 1'b0; m_word = 0; drops = 0; accepted = 0;
      fire_hist.delete();
      sb.delete();
    end else begin
      cyc++;
      if (fire_in) fire_hist[cyc] = 1'b1;
      hs   = m_valid && out_ready;
      fin  = hs && (m_word == NP - 1);
      prev = occ;
      if (fin) occ--;
      remain = occ;
      if (fire_hist.exists(cyc - DL)) begin
        if (occ < DEPTH) begin
          occ++;
          accepted++;
          for (int k = 0; k < NP; k++)
            sb.push_back(beat_t'{data: result_in[k*RW +: RW], idx: IW'(k), last: (k == NP - 1)});
        end else begin
          drops++;
        end
      end
      if (hs) begin
        if (!fin) m_word++;
        else if (remain > 0) m_word = 0;
        else m_valid = 1'b0;
      end else if (!m_valid && prev > 0) begin
        m_valid = 1'b1;
        m_word = 0;
      end
    end
  end

  initial forever begin
    bit fb;
    @(negedge clk);
    if (!rst) begin
      fb = 1'b0;
      for (int j = 0; j < DL; j++) fb |= fire_hist.exists(cyc - j);
      chk("valid", 64'(out_valid), 64'(m_valid));
      chk("overflow", 64'(overflow), 64'(drops != 0));
      chk("busy", 64'(busy), 64'(fb || occ > 0 || m_valid));
      if (out_valid && out_ready) begin
        words_seen++;
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL extra_word: got data %0h idx %0d with nothing expected", out_data, out_idx);
        end else begin
          chk("word", 64'({out_data, out_idx, out_last}), 64'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    int w0;
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_idx", 64'(out_idx), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));

    // Single fire with latency checks.
    result_in = {32'h4, 32'h3, 32'h2, 32'h1};
    out_ready = 1'b1;
    fire_in = 1'b1;
    step(1);
    fire_in = 1'b0;
    step(DL);
    chk("t1_no_early", 64'(out_valid), 64'(0));
    for (int k = 0; k < NP; k++) begin
      step(1);
      chk("t1_valid", 64'(out_valid), 64'(1));
      chk("t1_data", 64'(out_data), 64'(k + 1));
      chk("t1_idx", 64'(out_idx), 64'(k));
      chk("t1_last", 64'(out_last), 64'(k == NP - 1));
    end
    step(1);
    chk("t1_busy_low", 64'(busy), 64'(0));
    chk("t1_valid_low", 64'(out_valid), 64'(0));

    // Stall for six cycles on word 0.
    out_ready = 1'b0;
    fire_in = 1'b1;
    step(1);
    fire_in = 1'b0;
    wait_valid("t2_valid", 20);
    for (int i = 0; i < 6; i++) begin
      chk("t2_hold_valid", 64'(out_valid), 64'(1));
      chk("t2_hold_data", 64'(out_data), 64'(32'h1));
      chk("t2_hold_idx", 64'(out_idx), 64'(0));
      step(1);
    end
    drain("t2_drain");

    // Three back-to-back fires into a two-deep FIFO.
    rand_res = 1'b1;
    out_ready = 1'b0;
    fire_in = 1'b1;
    step(3);
    fire_in = 1'b0;
    step(DL + 2);
    chk("t3_overflow", 64'(overflow), 64'(1));
    chk("t3_valid", 64'(out_valid), 64'(1));
    w0 = words_seen;
    drain("t3_drain");
    chk("t3_words", 64'(words_seen - w0), 64'(2 * NP));

    // Last word accepted in the capture-strobe cycle of a full FIFO.
    do_reset();
    out_ready = 1'b0;
    fire_in = 1'b1;
    step(2);
    fire_in = 1'b0;
    wait_valid("t4_valid", 20);
    step(1);
    fire_in = 1'b1;
    step(1);
    fire_in = 1'b0;
    out_ready = 1'b1;
    step(NP);
    chk("t4_no_overflow", 64'(overflow), 64'(0));
    chk("t4_no_bubble", 64'(out_valid), 64'(1));
    chk("t4_idx0", 64'(out_idx), 64'(0));
    w0 = words_seen;
    drain("t4_drain");
    chk("t4_words", 64'(words_seen - w0), 64'(2 * NP));

    // Asynchronous reset while word 2 is pending.
    do_reset();
    out_ready = 1'b0;
    fire_in = 1'b1;
    step(3);
    fire_in = 1'b0;
    step(DL + 4);
    chk("t5_pre_overflow", 64'(overflow), 64'(1));
    out_ready = 1'b1;
    step(2);
    out_ready = 1'b0;
    chk("t5_pending_idx", 64'(out_idx), 64'(2));
    #1 rst = 1'b1;
    #2;
    chk("t5_async_valid", 64'(out_valid), 64'(0));
    chk("t5_async_data", 64'(out_data), 64'(0));
    chk("t5_async_idx", 64'(out_idx), 64'(0));
    chk("t5_async_last", 64'(out_last), 64'(0));
    chk("t5_async_busy", 64'(busy), 64'(0));
    chk("t5_async_overflow", 64'(overflow), 64'(0));
    step(2);
    rst = 1'b0;
    w0 = words_seen;
    out_ready = 1'b1;
    step(12);
    chk("t5_idle_valid", 64'(out_valid), 64'(0));
    chk("t5_no_words", 64'(words_seen - w0), 64'(0));

    // Random fire/ready traffic.
    do_reset();
    w0 = words_seen;
    for (int i = 0; i < 1600; i++) begin
      fire_in   = (i < 800) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    drain("t6_drain");
    chk("t6_vectors", 64'(words_seen - w0), 64'(accepted * NP));
    chk("t6_overflow", 64'(overflow), 64'(drops != 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
